// File: rtl/chip_slave_emu_if.sv
// Port bundle between the Master-side controller and the chip responder.
// The clock is not part of the bundle. It is the same net as the chip clk
// and is wired to the modules as a plain port.
interface chip_slave_emu_if;
  logic       CBL;
  logic       CBLEN;
  logic       CWL;
  logic       inference;
  logic       load_seed;
  logic       read_1;
  logic       read_8;
  logic       load_mem;
  logic       read_out;
  logic [7:0] addr_full_row;
  logic [7:0] addr_full_col;
  logic [7:0] seeds;
  logic [3:0] bit_out;

  modport master (
    output CBL, CBLEN, CWL, inference, load_seed, read_1, read_8,
           load_mem, read_out, addr_full_row, addr_full_col, seeds,
    input  bit_out
  );

  modport slave (
    input  CBL, CBLEN, CWL, inference, load_seed, read_1, read_8,
           load_mem, read_out, addr_full_row, addr_full_col, seeds,
    output bit_out
  );
endinterface

// File: rtl/chip_slave_emu.sv
// Chip-side responder that emulates the memristor array for bring-up without
// silicon. It holds a small array of probability words, four seedable LFSRs
// and a readout sequencer. Results are returned on bit_out.
module chip_slave_emu #(
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3,
  parameter int WORD_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  chip_slave_emu_if.slave  bus
);

  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, PROG, READ1, READ8, INFER} state_t;

  state_t state, next_state;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_reg;
  logic [WORD_W-1:0] lfsr [4];
  logic [WORD_W-1:0] infer_word [4];
  logic [COL_W-1:0]  lane_col [4];
  logic [3:0]        bit_q;
  logic [2:0]        pcnt;
  logic [2:0]        bcnt;
  logic [1:0]        seed_idx;
  logic              nib_lo;
  logic [ADDR_W-1:0] addr_idx;

  logic seed_cmd, prog_cmd, mem_cmd, infer_cmd, r8_cmd, r1_cmd;

  // Only the low address bits select a word; the upper bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_full_row[7:ROW_W], bus.addr_full_col[7:COL_W]};

  assign addr_idx = {bus.addr_full_row[ROW_W-1:0], bus.addr_full_col[COL_W-1:0]};

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Decode one command per cycle by priority and pick the next state.
  // A seed load leaves the state and the counters untouched.
  always_comb begin
    seed_cmd   = 1'b0;
    prog_cmd   = 1'b0;
    mem_cmd    = 1'b0;
    infer_cmd  = 1'b0;
    r8_cmd     = 1'b0;
    r1_cmd     = 1'b0;
    next_state = IDLE;
    if (bus.load_seed) begin
      seed_cmd   = 1'b1;
      next_state = state;
    end else if (bus.CWL && bus.CBLEN) begin
      prog_cmd   = 1'b1;
      next_state = PROG;
    end else if (bus.load_mem) begin
      mem_cmd    = 1'b1;
      next_state = IDLE;
    end else if (bus.inference) begin
      infer_cmd  = 1'b1;
      next_state = INFER;
    end else if (bus.read_8) begin
      r8_cmd     = 1'b1;
      next_state = READ8;
    end else if (bus.read_1) begin
      r1_cmd     = 1'b1;
      next_state = READ1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Look up the four words each inference lane compares against. Columns wrap within the row.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_col[i]   = bus.addr_full_col[COL_W-1:0] + COL_W'(i);
      infer_word[i] = mem[{bus.addr_full_row[ROW_W-1:0], lane_col[i]}];
    end
  end

  // Array bit writes while programming. Contents survive reset, but reset blocks new writes.
  always_ff @(posedge clk) begin
    if (rst_n && prog_cmd) mem[addr_idx][3'd7 - pcnt] <= bus.CBL;
  end

  // Datapath: seeds, counters, read register, result register and LFSR stepping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_q    <= 4'b0;
      rd_reg   <= '0;
      pcnt     <= 3'd0;
      bcnt     <= 3'd0;
      seed_idx <= 2'd0;
      nib_lo   <= 1'b0;
      lfsr[0]  <= 8'hA5;
      lfsr[1]  <= 8'h5A;
      lfsr[2]  <= 8'h3C;
      lfsr[3]  <= 8'hC3;
    end else if (seed_cmd) begin
      lfsr[seed_idx] <= (bus.seeds == 8'h00) ? 8'h01 : bus.seeds;
      seed_idx       <= seed_idx + 2'd1;
    end else begin
      pcnt   <= prog_cmd ? pcnt + 3'd1 : 3'd0;
      bcnt   <= r1_cmd ? bcnt + 3'd1 : 3'd0;
      nib_lo <= r8_cmd ? ~nib_lo : 1'b0;
      if (mem_cmd) rd_reg <= mem[addr_idx];
      if (r1_cmd) bit_q <= {3'b0, rd_reg[3'd7 - bcnt]};
      if (r8_cmd) bit_q <= nib_lo ? rd_reg[3:0] : rd_reg[7:4];
      if (infer_cmd) begin
        for (int i = 0; i < 4; i++) begin
          bit_q[i] <= (lfsr[i] < infer_word[i]);
          lfsr[i]  <= lfsr_next(lfsr[i]);
        end
      end
    end
  end

  assign bus.bit_out = bus.read_out ? bit_q : 4'b0;

endmodule

// File: tb/tb_chip_slave_emu.sv
// Directed testbench for chip_slave_emu. It covers reset, program and read
// paths, seeds, inference and command priority.
module tb_chip_slave_emu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  chip_slave_emu_if bus();

  chip_slave_emu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.CBL = 0; bus.CBLEN = 0; bus.CWL = 0; bus.inference = 0;
    bus.load_seed = 0; bus.read_1 = 0; bus.read_8 = 0; bus.load_mem = 0;
    bus.read_out = 0; bus.addr_full_row = 0; bus.addr_full_col = 0; bus.seeds = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic program_word(input logic [7:0] row, input logic [7:0] col, input logic [7:0] word);
    logic [7:0] w;
    w = word;
    bus.addr_full_row = row;
    bus.addr_full_col = col;
    bus.CWL = 1;
    bus.CBLEN = 1;
    for (int i = 0; i < 8; i++) begin
      bus.CBL = w[7-i];
      tick();
    end
    bus.CWL = 0;
    bus.CBLEN = 0;
    bus.CBL = 0;
  endtask

  task automatic seed_pulse(input logic [7:0] s);
    bus.load_seed = 1;
    bus.seeds = s;
    tick();
    bus.load_seed = 0;
  endtask

  task automatic infer_once(input logic [7:0] row, input logic [7:0] col);
    bus.addr_full_row = row;
    bus.addr_full_col = col;
    bus.inference = 1;
    tick();
    bus.inference = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      bus.read_out = 1;
      bus.CWL = i[0]; bus.CBLEN = 1; bus.CBL = ~i[0];
      bus.read_8 = 1; bus.read_1 = i[0]; bus.inference = ~i[0];
      bus.load_mem = i[0]; bus.load_seed = ~i[0]; bus.seeds = 8'h77;
      tick();
      checks++;
      if (bus.bit_out !== 4'h0) begin
        errors++;
        $display("[TB] FAIL reset_bit_out[%0d]: got %h expected %h", i, bus.bit_out, 4'h0);
      end
    end
    rst_n = 1;
    clear_inputs();
    bus.read_out = 1;
    bus.read_8 = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.bit_out !== 4'h0) begin
        errors++;
        $display("[TB] FAIL reset_rd_reg_nib[%0d]: got %h expected %h", i, bus.bit_out, 4'h0);
      end
    end
    bus.read_8 = 0;
  endtask

  task automatic test_program_read8();
    logic [3:0] exp_nib [2];
    exp_nib[0] = 4'hB;
    exp_nib[1] = 4'h4;
    program_word(8'd2, 8'd5, 8'hB4);
    bus.load_mem = 1;
    tick();
    bus.load_mem = 0;
    bus.read_out = 1;
    bus.read_8 = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.bit_out !== exp_nib[i]) begin
        errors++;
        $display("[TB] FAIL read8_nib[%0d]: got %h expected %h", i, bus.bit_out, exp_nib[i]);
      end
    end
    bus.read_8 = 0;
  endtask

  task automatic test_read1();
    logic [7:0] word;
    logic [3:0] exp;
    word = 8'hB4;
    bus.read_out = 1;
    bus.read_1 = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = {3'b0, word[7 - (i % 8)]};
      checks++;
      if (bus.bit_out !== exp) begin
        errors++;
        $display("[TB] FAIL read1_bit[%0d]: got %h expected %h", i, bus.bit_out, exp);
      end
    end
    bus.read_1 = 0;
  endtask

  task automatic test_seeds();
    // Lanes become 44,11,22,33. Equal words must give 0, and words one higher must give 1.
    do_reset();
    program_word(8'd1, 8'd0, 8'h44);
    program_word(8'd1, 8'd1, 8'h11);
    program_word(8'd1, 8'd2, 8'h22);
    program_word(8'd1, 8'd3, 8'h33);
    program_word(8'd1, 8'd4, 8'h45);
    program_word(8'd1, 8'd5, 8'h12);
    program_word(8'd1, 8'd6, 8'h23);
    program_word(8'd1, 8'd7, 8'h34);
    seed_pulse(8'h00); seed_pulse(8'h11); seed_pulse(8'h22); seed_pulse(8'h33); seed_pulse(8'h44);
    bus.read_out = 1;
    infer_once(8'd1, 8'd0);
    checks++;
    if (bus.bit_out !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL seed_lower_bound: got %b expected %b", bus.bit_out, 4'b0000);
    end
    do_reset();
    seed_pulse(8'h00); seed_pulse(8'h11); seed_pulse(8'h22); seed_pulse(8'h33); seed_pulse(8'h44);
    bus.read_out = 1;
    infer_once(8'd1, 8'd4);
    checks++;
    if (bus.bit_out !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL seed_upper_bound: got %b expected %b", bus.bit_out, 4'b1111);
    end
  endtask

  task automatic test_inference();
    logic [7:0] lane [4];
    logic [7:0] w1 [4];
    logic [7:0] w2 [4];
    logic [3:0] exp;
    lane[0] = 8'hFE; lane[1] = 8'h01; lane[2] = 8'h7F; lane[3] = 8'h01;
    w1[0] = 8'hFF; w1[1] = 8'h00; w1[2] = 8'h80; w1[3] = 8'h01;
    w2[0] = 8'hFC; w2[1] = 8'h03; w2[2] = 8'h80; w2[3] = 8'hFF;
    do_reset();
    program_word(8'd0, 8'd6, 8'hFF);
    program_word(8'd0, 8'd7, 8'h00);
    program_word(8'd0, 8'd0, 8'h80);
    program_word(8'd0, 8'd1, 8'h01);
    program_word(8'd0, 8'd3, 8'hFC);
    program_word(8'd0, 8'd4, 8'h03);
    program_word(8'd0, 8'd5, 8'h80);
    seed_pulse(8'hFE); seed_pulse(8'h01); seed_pulse(8'h7F); seed_pulse(8'h00);
    bus.read_out = 1;
    infer_once(8'd0, 8'd6);
    for (int i = 0; i < 4; i++) exp[i] = (lane[i] < w1[i]);
    checks++;
    if (bus.bit_out !== exp) begin
      errors++;
      $display("[TB] FAIL infer_first: got %b expected %b", bus.bit_out, exp);
    end
    infer_once(8'd0, 8'd3);
    for (int i = 0; i < 4; i++) exp[i] = (lfsr_step(lane[i]) < w2[i]);
    checks++;
    if (bus.bit_out !== exp) begin
      errors++;
      $display("[TB] FAIL infer_stepped: got %b expected %b", bus.bit_out, exp);
    end
  endtask

  task automatic test_priority_enable();
    do_reset();
    bus.read_out = 1;
    bus.addr_full_row = 8'd2;
    bus.addr_full_col = 8'd5;
    bus.load_seed = 1; bus.seeds = 8'h5A;
    bus.CWL = 1; bus.CBLEN = 1; bus.CBL = 0;
    bus.read_1 = 1;
    tick();
    bus.load_seed = 0; bus.CWL = 0; bus.CBLEN = 0; bus.read_1 = 0;
    checks++;
    if (bus.bit_out !== 4'h0) begin
      errors++;
      $display("[TB] FAIL priority_no_read1: got %h expected %h", bus.bit_out, 4'h0);
    end
    bus.load_mem = 1;
    tick();
    bus.load_mem = 0;
    bus.read_1 = 1;
    tick();
    bus.read_1 = 0;
    checks++;
    if (bus.bit_out !== 4'h1) begin
      errors++;
      $display("[TB] FAIL priority_no_write: got %h expected %h", bus.bit_out, 4'h1);
    end
    bus.read_out = 0;
    bus.read_8 = 1;
    tick();
    checks++;
    if (bus.bit_out !== 4'h0) begin
      errors++;
      $display("[TB] FAIL gate_disabled: got %h expected %h", bus.bit_out, 4'h0);
    end
    bus.read_out = 1;
    #1;
    checks++;
    if (bus.bit_out !== 4'hB) begin
      errors++;
      $display("[TB] FAIL gate_enabled_hi: got %h expected %h", bus.bit_out, 4'hB);
    end
    tick();
    checks++;
    if (bus.bit_out !== 4'h4) begin
      errors++;
      $display("[TB] FAIL gate_continue_lo: got %h expected %h", bus.bit_out, 4'h4);
    end
    bus.read_8 = 0;
  endtask

  // Run the scenarios in order and print the summary.
  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_program_read8();
    test_read1();
    test_seeds();
    test_inference();
    test_priority_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
